// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect/stall controls from later stages, the instruction
// memory port, and the decode-side view of the queue head.
interface fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              branchTaken;
    logic [ADDR_W-1:0] branchAddr;
    logic              freeze;
    logic [ADDR_W-1:0] imemAddr;
    logic [INST_W-1:0] imemInst;
    logic              imemReady;
    logic              instValid;
    logic [INST_W-1:0] instruction;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count;

    // Environment side: drives controls and memory data, observes the queue.
    modport master (
        output branchTaken, branchAddr, freeze, imemInst, imemReady,
        input  imemAddr, instValid, instruction, pc, count
    );

    // Queue side: the fetch_queue block itself.
    modport slave (
        input  branchTaken, branchAddr, freeze, imemInst, imemReady,
        output imemAddr, instValid, instruction, pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: a sequential fetch PC feeds a small circular
// buffer; decode consumes from the head. A taken branch flushes the queue and
// redirects the fetch PC. One cycle of latency from fetch to decode, no bypass.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Each entry carries the instruction and the address following it.
    typedef struct packed {
        logic [ADDR_W-1:0] nextPc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] stepPc;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  occupancy;
    logic              full;
    logic              empty;
    logic              deqFire;
    logic              enqFire;

    assign full    = (occupancy == CNT_W'(DEPTH));
    assign empty   = (occupancy == '0);
    // A branch discards the head, so it also suppresses the dequeue.
    assign deqFire = !empty && !bus.freeze && !bus.branchTaken;
    // A full queue can still accept when the head leaves in the same cycle.
    assign enqFire = bus.imemReady && !bus.branchTaken && (!full || deqFire);
    assign stepPc  = fetchPc + ADDR_W'(PC_STEP);

    assign bus.imemAddr  = fetchPc;
    assign bus.instValid = !empty;
    assign bus.count     = occupancy;

    // Head presentation: zeros while empty so stale storage never leaks out.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        bus.instruction = '0;
        bus.pc          = '0;
        if (!empty) begin
            bus.instruction = mem[rdPtr].inst;
            bus.pc          = mem[rdPtr].nextPc;
        end
    end

    // Control state: fetch PC, pointers and occupancy; reset beats branch beats normal flow.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            fetchPc   <= RESET_PC;
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else if (bus.branchTaken) begin
            fetchPc   <= bus.branchAddr;
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (enqFire) begin
                fetchPc <= stepPc;
                wrPtr   <= wrPtr + PTR_W'(1);
            end
            if (deqFire) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            occupancy <= occupancy + CNT_W'(enqFire) - CNT_W'(deqFire);
        end
    end

    // Entry storage write; contents only matter once occupancy covers them.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; occupancy alone decides which entries are live.
        if (enqFire) begin
            mem[wrPtr] <= '{nextPc: stepPc, inst: bus.imemInst};
        end
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, 32: PC and address width in bits.
REQ-002 Parameter INST_W, 32: instruction width in bits.
REQ-003 Parameter DEPTH, 4: prefetch queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, 0: PC value loaded on reset.
REQ-005 Parameter PC_STEP, 4: PC increment per sequential fetch.
REQ-006 Port clk, in, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst, in, 1: reset; synchronous, active-high.
REQ-008 Port branchTaken, in, 1: redirect request from a later stage.
REQ-009 Port branchAddr, in, ADDR_W: redirect target address.
REQ-010 Port freeze, in, 1: decode stall; blocks dequeue only.
REQ-011 Port imemAddr, out, ADDR_W: instruction memory address; equals the current fetch PC.
REQ-012 Port imemInst, in, INST_W: instruction memory data; combinational from imemAddr in the same cycle.
REQ-013 Port imemReady, in, 1: memory can accept a fetch this cycle.
REQ-014 Port instValid, out, 1: queue head holds a valid instruction.
REQ-015 Port instruction, out, INST_W: queue-head instruction.
REQ-016 Port pc, out, ADDR_W: queue-head fetch address + PC_STEP.
REQ-017 Port count, out, clog2(DEPTH+1): current queue occupancy.

Function
REQ-018 Fetch PC register drives imemAddr directly.
REQ-019 full = (count == DEPTH); empty = (count == 0); instValid = !empty.
REQ-020 deqFire = instValid && !freeze && !branchTaken.
REQ-021 enqFire = imemReady && !branchTaken && (!full || deqFire).
- Full queue with simultaneous dequeue accepts a new entry.
REQ-022 On enqFire:
- write {imemAddr+PC_STEP, imemInst} at the write pointer;
- advance the write pointer modulo DEPTH;
- fetch PC <= fetch PC + PC_STEP, modulo 2^ADDR_W.
REQ-023 On deqFire, advance the read pointer modulo DEPTH.
REQ-024 count next = count + enqFire - deqFire; it never exceeds DEPTH and never underflows.
REQ-025 No bypass: a fetched instruction appears on the outputs no earlier than the next cycle (1-cycle fetch-to-decode latency).
REQ-026 When empty: instruction = 0 and pc = 0.
REQ-027 branchTaken has priority over freeze, imemReady and dequeue. In that cycle:
- count <= 0 and both pointers <= 0 (head discarded, wrong path);
- fetch PC <= branchAddr;
- no enqueue and no dequeue.
REQ-028 After a branch, the first fetch from branchAddr occurs the next cycle; its instruction becomes valid one cycle later.
REQ-029 Back-to-back branchTaken cycles: the last branchAddr wins; the queue stays empty throughout.
REQ-030 imemReady low: fetch PC holds and nothing is enqueued; dequeue continues.
REQ-031 freeze high: outputs hold stable; fetch continues until the queue is full, then fetch PC holds.
REQ-032 Queue entries are presented in fetch order with no loss or duplication across pointer wrap-around.

Reset
REQ-033 While rst is high at a clock edge:
- fetch PC <= RESET_PC;
- count, read pointer and write pointer <= 0;
- instValid = 0, instruction = 0, pc = 0 after that edge.
REQ-034 rst overrides branchTaken and all other inputs.
REQ-035 Reset asserted mid-operation discards all queued entries.
REQ-036 Queue storage is not required to be reset.
REQ-037 First fetch occurs in the first cycle with rst low.

Verification
Setup: DEPTH=4, RESET_PC=0, PC_STEP=4; imemInst = imemAddr XOR 32'hE000_0000.
REQ-038 Reset release, imemReady=1, freeze=0 -> instValid rises 1 cycle later; heads 0xE0000000/pc=4, then 0xE0000004/pc=8, one per cycle; count stays 1.
REQ-039 freeze=1 for 8 cycles -> count climbs to 4 and holds; imemAddr holds at 0x10; head unchanged. After release: heads for addresses 0x0, 0x4, 0x8, 0xC in order, then 0x10 one cycle later.
REQ-040 Full queue, branchTaken=1, branchAddr=0x100, freeze=1 -> next cycle count=0, instValid=0, imemAddr=0x100. One cycle later: instruction=0xE0000100, pc=0x104.
REQ-041 imemReady toggled 1,0,1,0 with freeze=0 -> valid entries every other cycle; no duplicated or skipped addresses.
REQ-042 rst pulsed with count=3 -> next cycle count=0, instValid=0, imemAddr=0. Fetch restarts at 0.
REQ-043 branchAddr=0xFFFF_FFFC, no freeze -> next fetch address wraps to 0x0; the pc for the 0xFFFF_FFFC entry equals 0x0.
